// File: rtl/reg_file_sb_if.sv
// Register-file bus: one write port, two read ports, scoreboard lock port and status.
// The controller drives the master side, the register file implements the slave side.
interface reg_file_sb_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] sr;
    logic [AW-1:0] dr;
    logic [DW-1:0] s;
    logic [DW-1:0] d;
    logic          lock;
    logic [AW-1:0] la;
    logic          s_busy;
    logic          d_busy;
    logic          any_busy;
    logic          lock_err;

    modport master (
        output we, wa, wd, sr, dr, lock, la,
        input  s, d, s_busy, d_busy, any_busy, lock_err
    );

    modport slave (
        input  we, wa, wd, sr, dr, lock, la,
        output s, d, s_busy, d_busy, any_busy, lock_err
    );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-register file with two combinational read ports, one write port,
// optional write-to-read bypass and a per-register busy scoreboard for RAW hazards.
module reg_file_sb #(
    parameter int               DW        = 8,
    parameter int               AW        = 2,
    parameter bit               BYPASS    = 1'b1,
    parameter logic [DW-1:0]    RST_FIRST = 8'h01,
    parameter logic [DW-1:0]    RST_LAST  = 8'h07
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int NREG = 2 ** AW;

    logic [DW-1:0]   mem_reg [NREG];
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic            lock_err_reg;
    logic            lock_err_next;

    logic [NREG-1:0] wr_sel;
    logic [NREG-1:0] lk_sel;
    logic [DW-1:0]   rst_val [NREG];

    // Per-register decode of write/lock strobes and reset values.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_dec
            assign wr_sel[gi] = bus.we   && (bus.wa == AW'(gi));
            assign lk_sel[gi] = bus.lock && (bus.la == AW'(gi));
            if (gi == 0) begin : g_first
                assign rst_val[gi] = RST_FIRST;
            end else if (gi == NREG - 1) begin : g_last
                assign rst_val[gi] = RST_LAST;
            end else begin : g_mid
                assign rst_val[gi] = '0;
            end
        end
    endgenerate

    // A lock on the register being written wins: the lock names a new producer.
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            always_comb begin
                busy_next[gi] = busy_reg[gi];
                if (lk_sel[gi]) begin
                    busy_next[gi] = 1'b1;
                end else if (wr_sel[gi]) begin
                    busy_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // Locking a register whose result is still pending is an error, unless the
    // pending result is being delivered on this very edge.
    always_comb begin
        lock_err_next = 1'b0;
        if (bus.lock && busy_reg[bus.la] && !(bus.we && bus.wa == bus.la)) begin
            lock_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= rst_val[i];
            end
            busy_reg     <= '0;
            lock_err_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= bus.wd;
                end
            end
            busy_reg     <= busy_next;
            lock_err_reg <= lock_err_next;
        end
    end

    logic s_hit;
    logic d_hit;

    assign s_hit = BYPASS && bus.we && (bus.wa == bus.sr);
    assign d_hit = BYPASS && bus.we && (bus.wa == bus.dr);

    always_comb begin
        bus.s      = mem_reg[bus.sr];
        bus.d      = mem_reg[bus.dr];
        bus.s_busy = busy_reg[bus.sr];
        bus.d_busy = busy_reg[bus.dr];
        if (s_hit) begin
            bus.s      = bus.wd;
            bus.s_busy = 1'b0;
        end
        if (d_hit) begin
            bus.d      = bus.wd;
            bus.d_busy = 1'b0;
        end
    end

    assign bus.any_busy = |busy_reg;
    assign bus.lock_err = lock_err_reg;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: a bypassing and a non-bypassing register file share one stimulus stream.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file_sb_if #(.DW(8), .AW(2)) ifa ();
    reg_file_sb_if #(.DW(8), .AW(2)) ifb ();

    assign ifb.we   = ifa.we;
    assign ifb.wa   = ifa.wa;
    assign ifb.wd   = ifa.wd;
    assign ifb.sr   = ifa.sr;
    assign ifb.dr   = ifa.dr;
    assign ifb.lock = ifa.lock;
    assign ifb.la   = ifa.la;

    reg_file_sb #(.DW(8), .AW(2), .BYPASS(1'b1), .RST_FIRST(8'h01), .RST_LAST(8'h07))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    reg_file_sb #(.DW(8), .AW(2), .BYPASS(1'b0), .RST_FIRST(8'h01), .RST_LAST(8'h07))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifa.we = 0; ifa.wa = 0; ifa.wd = 0; ifa.sr = 0; ifa.dr = 0; ifa.lock = 0; ifa.la = 0;
        tick();
        rst = 1'b0;

        // 1 reset values
        ifa.sr = 2'd0; ifa.dr = 2'd1; #1;
        chk("rst_r0", ifa.s, 8'h01);
        chk("rst_r1", ifa.d, 8'h00);
        ifa.sr = 2'd2; ifa.dr = 2'd3; #1;
        chk("rst_r2", ifa.s, 8'h00);
        chk("rst_r3", ifa.d, 8'h07);
        chk("rst_r3_b", ifb.d, 8'h07);
        chk("rst_any_busy", {7'd0, ifa.any_busy}, 8'h00);
        chk("rst_lock_err", {7'd0, ifa.lock_err}, 8'h00);

        // 2 write then read
        ifa.we = 1; ifa.wa = 2'd2; ifa.wd = 8'hA5;
        tick();
        ifa.we = 0; #1;
        chk("wr_s_r2", ifa.s, 8'hA5);
        chk("wr_s_r2_b", ifb.s, 8'hA5);
        chk("wr_d_r3", ifa.d, 8'h07);
        chk("wr_lock_err", {7'd0, ifa.lock_err}, 8'h00);

        // 3 bypass vs. stored value
        ifa.we = 1; ifa.wa = 2'd1; ifa.wd = 8'h3C; ifa.sr = 2'd1; ifa.dr = 2'd1; #1;
        chk("byp_s", ifa.s, 8'h3C);
        chk("byp_d", ifa.d, 8'h3C);
        chk("nobyp_s", ifb.s, 8'h00);
        tick();
        ifa.we = 0; #1;
        chk("nobyp_s_after", ifb.s, 8'h3C);

        // 4 scoreboard
        ifa.lock = 1; ifa.la = 2'd2;
        tick();
        ifa.lock = 0; ifa.sr = 2'd2; #1;
        chk("sb_s_busy", {7'd0, ifa.s_busy}, 8'h01);
        chk("sb_any_busy", {7'd0, ifa.any_busy}, 8'h01);
        chk("sb_lock_err", {7'd0, ifa.lock_err}, 8'h00);
        ifa.we = 1; ifa.wa = 2'd2; ifa.wd = 8'h11; #1;
        chk("sb_byp_busy", {7'd0, ifa.s_busy}, 8'h00);
        chk("sb_nobyp_busy", {7'd0, ifb.s_busy}, 8'h01);
        tick();
        ifa.we = 0; #1;
        chk("sb_clr_busy", {7'd0, ifa.s_busy}, 8'h00);
        chk("sb_clr_any", {7'd0, ifa.any_busy}, 8'h00);
        chk("sb_clr_s", ifa.s, 8'h11);

        // 5 lock error pulse
        ifa.lock = 1; ifa.la = 2'd3;
        tick();
        chk("le_first", {7'd0, ifa.lock_err}, 8'h00);
        tick();
        chk("le_second", {7'd0, ifa.lock_err}, 8'h01);
        ifa.lock = 0;
        tick();
        chk("le_third", {7'd0, ifa.lock_err}, 8'h00);
        ifa.we = 1; ifa.wa = 2'd3; ifa.wd = 8'h07;
        tick();
        ifa.we = 0;
        ifa.lock = 1; ifa.la = 2'd3;
        tick();
        chk("le2_first", {7'd0, ifa.lock_err}, 8'h00);
        ifa.we = 1; ifa.wa = 2'd3; ifa.wd = 8'h22;
        tick();
        ifa.we = 0; ifa.lock = 0; ifa.dr = 2'd3; #1;
        chk("le2_second", {7'd0, ifa.lock_err}, 8'h00);
        chk("le2_busy3", {7'd0, ifa.d_busy}, 8'h01);
        chk("le2_data3", ifa.d, 8'h22);
        chk("le2_any", {7'd0, ifa.any_busy}, 8'h01);

        // 6 reset mid-operation
        ifa.lock = 1; ifa.la = 2'd1;
        tick();
        ifa.la = 2'd2;
        tick();
        ifa.lock = 0;
        rst = 1; ifa.we = 1; ifa.wa = 2'd0; ifa.wd = 8'hFF;
        tick();
        rst = 0; ifa.we = 0; ifa.sr = 2'd0; ifa.dr = 2'd2; #1;
        chk("mid_r0", ifa.s, 8'h01);
        chk("mid_r2", ifa.d, 8'h00);
        chk("mid_d_busy", {7'd0, ifa.d_busy}, 8'h00);
        chk("mid_any", {7'd0, ifa.any_busy}, 8'h00);
        chk("mid_lock_err", {7'd0, ifa.lock_err}, 8'h00);
        ifa.lock = 1; ifa.la = 2'd2;
        tick();
        rst = 1;
        tick();
        rst = 0; ifa.lock = 0; #1;
        chk("rstlock_err", {7'd0, ifa.lock_err}, 8'h00);
        chk("rstlock_any", {7'd0, ifa.any_busy}, 8'h00);
        tick();
        chk("rstlock_err2", {7'd0, ifa.lock_err}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
